// File: rtl/mmio_uart_fifo.sv
// MMIO front-end for the on-chip UART: TX/RX FIFOs, sticky overflow flags,
// level reporting, flush, and cycle/instruction counters with 1-cycle read latency.
module mmio_uart_fifo_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [7:0]                 data_i,
  output logic [7:0]                 data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, empty, do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && !do_push && !flush_i;
  assign data_o  = mem[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_ptr_q] <= data_i;
  end
endmodule

module mmio_uart_fifo #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic        sel, wr_en, rd_en;
  logic [7:0]  off;
  logic        tx_push, tx_pop, rx_pop, ctrl_wr, cnt_rst, flush, clr;
  logic        tx_ovf_new, rx_ovf_new;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [31:0] cyc_q, cyc_d, inst_cnt_q, inst_cnt_d, rdata_q, rdata_d, rd_mux, status;
  logic [7:0]  rx_head;
  logic [$clog2(TX_DEPTH):0] tx_level;
  logic [$clog2(RX_DEPTH):0] rx_level;
  logic        unused_ok;

  assign sel     = (addr[31:28] == BASE_NIBBLE);
  assign off     = addr[7:0];
  assign wr_en   = sel && (we != '0);
  assign rd_en   = sel && re;
  assign tx_push = wr_en && (off == 8'h08);
  assign ctrl_wr = wr_en && (off == 8'h0C);
  assign cnt_rst = wr_en && (off == 8'h18);
  assign rx_pop  = rd_en && (off == 8'h04);
  assign flush   = ctrl_wr && wdata[1];
  assign clr     = ctrl_wr && wdata[0];
  assign tx_valid = (tx_level != '0);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = 1'b1;
  assign unused_ok = ^{addr[27:8], wdata[31:8]};

  mmio_uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .flush_i(flush), .push_i(tx_push), .pop_i(tx_pop),
    .data_i(wdata[7:0]), .data_o(tx_data), .level_o(tx_level), .ovf_o(tx_ovf_new)
  );

  mmio_uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .flush_i(flush), .push_i(rx_valid), .pop_i(rx_pop),
    .data_i(rx_data), .data_o(rx_head), .level_o(rx_level), .ovf_o(rx_ovf_new)
  );

  assign status = {8'h00, 8'(tx_level), 8'(rx_level), 4'h0,
                   tx_ovf_q, rx_ovf_q, (rx_level != '0), (tx_level != TX_DEPTH[$clog2(TX_DEPTH):0])};

  always_comb begin
    rd_mux = '0;
    case (off)
      8'h00: rd_mux = status;
      8'h04: rd_mux = (rx_level != '0) ? {24'h0, rx_head} : '0;
      8'h10: rd_mux = cyc_q;
      8'h14: rd_mux = inst_cnt_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    rdata_d    = rdata_q;
    if (re) rdata_d = sel ? rd_mux : '0;
    // A new overflow outranks a same-cycle clear.
    tx_ovf_d   = (tx_ovf_q && !clr) || tx_ovf_new;
    rx_ovf_d   = (rx_ovf_q && !clr) || rx_ovf_new;
    cyc_d      = cnt_rst ? '0 : cyc_q + 32'd1;
    inst_cnt_d = cnt_rst ? '0 : inst_cnt_q + 32'(inst_retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      cyc_q      <= '0;
      inst_cnt_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      cyc_q      <= cyc_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Scoreboard bench for mmio_uart_fifo: queues model both FIFOs and the flags.
module tb_mmio_uart_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  we = '0;
  logic        re = 1'b0, inst_retire = 1'b0;
  logic [7:0]  tx_data, rx_data = '0;
  logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic tx_ovf_m = 1'b0, rx_ovf_m = 1'b0;

  localparam logic [31:0] BASE = 32'h8000_0000;

  mmio_uart_fifo #(.TX_DEPTH(8), .RX_DEPTH(8), .BASE_NIBBLE(4'h8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .inst_retire(inst_retire), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // TX output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      n_checks++;
      if (txq.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got tx_data=%02h, expected no transmit", tx_data);
      end else begin
        logic [7:0] e;
        e = txq.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_data: got %02h, expected %02h", tx_data, e);
        end
      end
    end
  end

  function automatic logic [31:0] exp_status();
    return {8'h00, 8'(txq.size()), 8'(rxq.size()), 4'h0,
            tx_ovf_m, rx_ovf_m, (rxq.size() != 0), (txq.size() < 8)};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1; cyc(); re = 1'b0; addr = '0; d = rdata;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 4'hF; cyc(); we = '0; addr = '0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    if (txq.size() < 8) txq.push_back(b); else tx_ovf_m = 1'b1;
    bus_wr(BASE + 32'h08, {24'h0, b});
  endtask

  task automatic rx_push(input logic [7:0] b);
    if (rxq.size() < 8) rxq.push_back(b); else rx_ovf_m = 1'b1;
    rx_valid = 1'b1; rx_data = b; cyc(); rx_valid = 1'b0;
  endtask

  task automatic rx_read(output logic [31:0] d);
    logic [31:0] e;
    e = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    bus_rd(BASE + 32'h04, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL rx_read: got %08h, expected %08h", d, e); end
  endtask

  task automatic check_status(input string nm);
    logic [31:0] d, e;
    e = exp_status();
    bus_rd(BASE, d);
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL %s: got %08h, expected %08h", nm, d, e); end
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 50; i++) begin
      if (txq.size() == 0) break;
      cyc();
    end
    cyc();
    n_checks++;
    if (txq.size() != 0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_drain: got %0d pending, tx_valid=%b, expected 0 pending and tx_valid=0",
               txq.size(), tx_valid);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n_checks++;
    if (rdata !== 32'h0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got rdata=%08h tx_valid=%b, expected 0/0", rdata, tx_valid);
    end
    for (int i = 0; i < 5; i++) cyc();
    bus_rd(BASE + 32'h10, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL cycle_cnt_after_reset: got %0d, expected 5", d); end
    check_status("status_reset");
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) tx_push(8'h41 + 8'(i));
    check_status("status_tx_full");
    tx_ready = 1'b1;
    wait_tx_drain();
    tx_ready = 1'b0;
    bus_wr(BASE + 32'h0C, 32'h1); tx_ovf_m = 1'b0;
    check_status("status_tx_ovf_clear");
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
    check_status("status_rx_full");
    for (int i = 0; i < 9; i++) rx_read(d);
    bus_wr(BASE + 32'h0C, 32'h1); rx_ovf_m = 1'b0;
    check_status("status_rx_ovf_clear");
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, e;
    for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i));
    e = {24'h0, rxq.pop_front()};
    rxq.push_back(8'h99);
    addr = BASE + 32'h04; re = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    cyc();
    re = 1'b0; rx_valid = 1'b0; addr = '0; d = rdata;
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL full_pushpop_head: got %08h, expected %08h", d, e); end
    check_status("status_full_pushpop");
    for (int i = 0; i < 8; i++) rx_read(d);
    n_checks++;
    if (d !== 32'h99) begin n_fail++; $display("FAIL full_pushpop_last: got %08h, expected 00000099", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_push(8'hA0 + 8'(i));
    for (int i = 0; i < 2; i++) rx_push(8'hB0 + 8'(i));
    addr = BASE + 32'h0C; wdata = 32'h2; we = 4'hF; rx_valid = 1'b1; rx_data = 8'h55;
    cyc();
    we = '0; rx_valid = 1'b0; addr = '0;
    txq.delete(); rxq.delete();
    check_status("status_after_flush");
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_tx_valid: got %b, expected 0", tx_valid); end
    rx_read(d);
  endtask

  task automatic test_counters();
    logic [31:0] d;
    bus_wr(BASE + 32'h18, 32'h0);
    inst_retire = 1'b1; for (int i = 0; i < 100; i++) cyc(); inst_retire = 1'b0;
    bus_wr(BASE + 32'h18, 32'h0);
    inst_retire = 1'b1; for (int i = 0; i < 3; i++) cyc(); inst_retire = 1'b0;
    bus_rd(BASE + 32'h14, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL inst_cnt: got %0d, expected 3", d); end
    bus_wr(BASE + 32'h18, 32'h0);
    bus_rd(BASE + 32'h10, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL cycle_cnt_rst: got %0d, expected 0", d); end
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.inst_cnt_q;
    inst_retire = 1'b1; cyc(); inst_retire = 1'b0;
    bus_rd(BASE + 32'h14, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL inst_cnt_wrap: got %08h, expected 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, held;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tx_push(8'h77 + 8'(i));
    wait_tx_drain();
    tx_ready = 1'b0;
    bus_rd(BASE + 32'h10, held);
    for (int i = 0; i < 3; i++) cyc();
    n_checks++;
    if (rdata !== held) begin n_fail++; $display("FAIL rdata_hold: got %08h, expected %08h", rdata, held); end
    bus_rd(BASE + 32'h1C, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %08h, expected 0", d); end
    bus_rd(BASE + 32'h10, d);
    bus_rd(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unselected_read: got %08h, expected 0", d); end
    bus_wr(32'h0000_0008, 32'hEE);
    check_status("status_unselected_write");
  endtask

  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_overflow();
    test_full_push_pop();
    test_flush();
    test_counters();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
- Memory-mapped I/O controller that sits between the CPU memory stage and the on-chip uart module.
- Adds parametrised TX/RX FIFOs, sticky overflow flags, FIFO level reporting, flush, and cycle/instruction performance counters.
- Decodes the I/O region (addr[31:28] == BASE_NIBBLE) and returns read data with one-cycle latency, matching the BIOS/DMEM timing, so the writeback mux treats it like any synchronous memory.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of 2, 2..128.
- RX_DEPTH, 8, RX FIFO entries; power of 2, 2..128.
- BASE_NIBBLE, 4'h8, value of addr[31:28] that selects this block.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- addr  input  32  byte address from the memory stage.
- wdata  input  32  store data, already lane-shifted.
- we  input  4  byte write mask; nonzero means write.
- re  input  1  load strobe.
- inst_retire  input  1  one retired instruction this cycle.
- rdata  output  32  registered read data.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  TX FIFO not empty.
- tx_ready  input  1  transmitter accepts the byte.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  receiver byte valid.
- rx_ready  output  1  always 1 (the block never backpressures the receiver).

Behaviour:
- sel = (addr[31:28] == BASE_NIBBLE). Offset = addr[7:0]. Writes and reads with sel low are ignored; rdata for them is 0.
- Register map:
  - 0x00 STATUS (read): bit0 = TX not full; bit1 = RX not empty; bit2 = rx_overflow; bit3 = tx_overflow; [15:8] = RX level; [23:16] = TX level; all other bits 0. Bits 0/1 stay software-compatible with the existing UART control word.
  - 0x04 RX_DATA (read): returns {24'b0, RX head} and pops the RX FIFO. When RX is empty, returns 0 and does not pop.
  - 0x08 TX_DATA (write): pushes wdata[7:0]. When TX is full, the byte is dropped and tx_overflow is set.
  - 0x0C CTRL (write): bit0 = 1 clears both overflow flags; bit1 = 1 flushes both FIFOs (levels go to 0 next cycle; pushes in the same cycle are discarded).
  - 0x10 CYCLE_CNT (read).
  - 0x14 INST_CNT (read).
  - 0x18 CNT_RST (write, any data): both counters read 0 next cycle.
  - Unmapped offsets read 0; writes to them are ignored.
- Read latency: rdata is registered. The value for a read at cycle N appears at cycle N+1 and holds until the next re. A read with re low leaves rdata unchanged. The STATUS snapshot is taken at cycle N, before any push or pop that happens in cycle N.
- The RX pop happens on the re cycle (cycle N), not the data cycle.
- FIFOs use circular buffers with read/write pointers and an explicit level counter of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- tx_data is the combinational TX head; tx_valid = (tx_level != 0). A TX pop occurs when tx_valid && tx_ready.
- RX push occurs when rx_valid is high. If RX is full and no pop happens that cycle, the byte is dropped and rx_overflow is set.
- Simultaneous push and pop:
  - On a full FIFO: both happen, level unchanged, no overflow.
  - On an empty FIFO: the push happens, the pop does not. There is no bypass; data becomes visible the next cycle.
- Overflow flags are sticky. A clear and a new overflow in the same cycle leaves the flag set.
- Flush versus a same-cycle pop: flush wins, and the popped read still returns the pre-flush head.
- CYCLE_CNT increments every cycle after reset. INST_CNT increments on inst_retire. Both are 32-bit and wrap from 0xFFFF_FFFF to 0. CNT_RST takes precedence over the increment.
- Reset (rst high at a clock edge): levels, pointers, flags and counters go to 0; rdata = 0; tx_valid = 0. A reset mid-transfer discards FIFO contents. FIFO storage is not cleared.

Test Plan:
- After reset: read 0x00 -> rdata = 0x0000_0001 next cycle; tx_valid = 0; CYCLE_CNT read 5 cycles after reset release = 5 (±1 for the read cycle, fixed in the bench).
- With tx_ready = 0, write 0x41..0x48 to 0x08 (TX_DEPTH = 8), then a 9th write of 0x49 -> STATUS = 0x0008_0008 (TX full, tx_overflow set). Raise tx_ready -> tx_data sequence 0x41..0x48; 0x49 is never sent.
- Drive rx_valid with 0x10..0x18 (9 bytes, no reads) -> STATUS[15:8] = 8, bit2 = 1. Nine reads of 0x04 return 0x10..0x17, then 0. Write CTRL = 1 -> bit2 = 0.
- With RX full, pulse rx_valid (0x99) in the same cycle as a read of 0x04 -> read returns the old head, level stays 8, rx_overflow stays 0, and 0x99 is the last byte read out.
- Push 3 TX bytes and 2 RX bytes, then write CTRL = 2 in the same cycle as an rx_valid of 0x55 -> STATUS next cycle = 0x0000_0001, tx_valid = 0, and 0x55 is lost.
- Pulse inst_retire 100 times, write 0x18, pulse 3 more -> INST_CNT = 3. Preload by force to 0xFFFF_FFFF and pulse once -> INST_CNT = 0.
